alu_seq: RTL and testbench
==========================

# alu_seq

Nibble-serial ALU sequencer for the Z80 core. Accepts an 8-bit arithmetic/logic request, latches operands, runs the low nibble then the high nibble through a 4-bit datapath, and chains carry, parity and zero between the two passes. It delivers the 8-bit result and a Z80-format flag byte. It sits directly upstream of the flag register and accumulator write-back, and mirrors the two-pass nibble scheme of the 4-bit ALU core.

## Interface
Parameters: none.

- clk  in  1  core clock; all state changes on rising edge
- nreset  in  1  asynchronous, active-low reset
- start  in  1  request strobe; sampled only in IDLE or DONE
- op  in  3  0 ADD, 1 ADC, 2 SUB, 3 SBC, 4 AND, 5 XOR, 6 OR, 7 CP
- op1  in  8  first operand (accumulator)
- op2  in  8  second operand
- cf_in  in  1  carry flag input; used only by ADC and SBC
- busy  out  1  high in LOW and HIGH states
- done  out  1  one-cycle pulse; result and flags valid
- result  out  8  operation result; held until next accepted start
- flags  out  8  {S,Z,Y,H,X,PV,N,C}, bit 7 down to bit 0
- alu_op_low  out  1  high in the LOW state (nibble phase indicator)

## Operation
- States: IDLE, LOW, HIGH, DONE. Reset enters IDLE.
- IDLE/DONE with start=1: latch op, op1, op2, cf_in, then go to LOW. Without start: DONE goes to IDLE, IDLE stays.
- LOW: compute low nibble from op1[3:0], op2[3:0], carry-in. Store the 4-bit result, the nibble carry or borrow (H), the low zero bit and the low parity. Next state is HIGH.
- HIGH: compute high nibble with the carry from LOW. Form the 8-bit result, C, overflow, S, Z and parity. Update result and flags. Next state is DONE.
- Carry-in to LOW: ADD, SUB and CP use 0. ADC and SBC use the latched cf_in.
- Subtraction is op1 + ~op2 + ~cin, with carry out inverted to give borrow.
- Flags:
  - S = r[7]; Z = (r == 0).
  - H = low-nibble carry or borrow; AND forces 1; XOR and OR force 0.
  - PV = signed overflow for ops 0–3 and 7; even parity of r (1 = even) for ops 4–6.
  - N = 1 for SUB, SBC and CP, else 0.
  - C = carry or borrow for arithmetic ops; 0 for logic ops.
- CP: flags come from op1−op2. result = op1 (unchanged). Y and X are taken from op2 instead of r.
- start while busy is ignored. It is neither queued nor latched.
- Input changes after the accepting edge have no effect.

## Timing
- Reset values: busy=0, done=0, result=8'h00, flags=8'h00, alu_op_low=0. State is IDLE.
- Cycle-level sequence:
  - Edge E0 accepts start.
  - During cycle E0–E1: LOW, busy=1, alu_op_low=1.
  - During E1–E2: HIGH, busy=1.
  - At E2, result and flags update. During E2–E3, done=1 and busy=0.
- Latency is 3 edges from the accepting edge to done-high sampled.
- Back-to-back: start=1 during DONE is accepted at E3, so the sustained rate is one operation per 3 cycles.
- result and flags change only at the HIGH→DONE edge and on reset.
- nreset asserted mid-operation: immediate return to IDLE, all outputs to reset values, and the in-flight operation is discarded without a done pulse.

## Configuration
- ALU_SEQ_XY_EN defined: flags[5] (Y) and flags[3] (X) follow result bits 5 and 3, or op2 bits 5 and 3 for CP.
- ALU_SEQ_XY_EN undefined: flags[5] and flags[3] are forced to 0. All other behaviour is identical.

## Test plan
- ADD, op1=0x0F, op2=0x01 → done at 3rd edge; result=0x10, flags=0x10 (H only).
- SUB, op1=0x80, op2=0x01 → result=0x7F, flags=0x3E with XY_EN, 0x16 without.
- ADC, op1=0xFF, op2=0x00, cf_in=1 → result=0x00, flags=0x51 (Z, H, C).
- XOR, op1=0x5A, op2=0x5A → result=0x00, flags=0x44 (Z, P even); then back-to-back AND, op1=0xF0, op2=0x3C → result=0x30, flags=0x34 with XY_EN (Y, H, P), 0x14 without.
- CP, op1=0x10, op2=0x28 → result=0x10, flags=0xBB with XY_EN, 0x93 without.
- Accept ADD, then drive start with new operands during LOW → ignored, one done only. Then assert nreset during HIGH → busy=0, done=0, result=0x00, flags=0x00, no done pulse.

Source files
------------

// File: rtl/alu_seq.sv
// -----------------------------------------------------------------------------
// alu_seq -- nibble-serial ALU sequencer for the Z80 core.
//
// An accepted request latches op/op1/op2/cf_in, runs the low nibble then the
// high nibble through one shared 4-bit datapath, and chains carry, zero and
// parity between the two passes. The 8-bit result and a Z80 flag byte
// {S,Z,Y,H,X,PV,N,C} update on the HIGH->DONE edge, and done pulses for one
// cycle. One operation completes every 3 cycles when requests are chained
// back to back.
//
// Ports:
//   clk         core clock, rising edge
//   nreset      asynchronous active-low reset
//   start       request strobe, sampled only in IDLE or DONE
//   op[2:0]     0 ADD, 1 ADC, 2 SUB, 3 SBC, 4 AND, 5 XOR, 6 OR, 7 CP
//   op1[7:0]    first operand (accumulator)
//   op2[7:0]    second operand
//   cf_in       carry flag in, used by ADC and SBC only
//   busy        high in LOW and HIGH
//   done        one-cycle pulse, result and flags valid
//   result[7:0] operation result, held until the next completed operation
//   flags[7:0]  {S,Z,Y,H,X,PV,N,C}
//   alu_op_low  high in LOW (nibble phase indicator)
//
// Configuration macro: ALU_SEQ_XY_EN -- when defined, Y/X copy bits 5/3 of
// the result (of op2 for CP); when undefined they read as 0.
// -----------------------------------------------------------------------------
module alu_seq (
    input  logic       clk,
    input  logic       nreset,
    input  logic       start,
    input  logic [2:0] op,
    input  logic [7:0] op1,
    input  logic [7:0] op2,
    input  logic       cf_in,
    output logic       busy,
    output logic       done,
    output logic [7:0] result,
    output logic [7:0] flags,
    output logic       alu_op_low
);

    typedef enum logic [1:0] {S_IDLE, S_LOW, S_HIGH, S_DONE} state_t;
    typedef enum logic [2:0] {
        OP_ADD, OP_ADC, OP_SUB, OP_SBC, OP_AND, OP_XOR, OP_OR, OP_CP
    } op_t;

    state_t     r_state, w_next_state;
    op_t        r_op;
    logic [7:0] r_a, r_b;
    logic       r_cf;
    logic [3:0] r_lo_res;
    logic       r_c_mid;     // raw adder carry out of the low nibble
    logic       r_lo_zero;
    logic       r_lo_even;   // 1 = low nibble has even parity
    logic [7:0] r_result, r_flags;

    // Operation class decode
    logic w_is_sub, w_is_logic, w_use_cf;
    assign w_is_sub   = (r_op == OP_SUB) || (r_op == OP_SBC) || (r_op == OP_CP);
    assign w_is_logic = (r_op == OP_AND) || (r_op == OP_XOR) || (r_op == OP_OR);
    assign w_use_cf   = (r_op == OP_ADC) || (r_op == OP_SBC);

    // Shared nibble datapath. Subtraction is a + ~b + ~cin, so the adder
    // carry-in is inverted for the subtract class and the raw carry chains
    // straight into the high nibble; borrow is recovered only for H and C.
    logic       w_in_high;
    logic [3:0] w_nib_a, w_nib_b, w_nib_res;
    logic       w_cin_low, w_nib_cin;
    logic [4:0] w_sum;

    assign w_in_high = (r_state == S_HIGH);
    assign w_nib_a   = w_in_high ? r_a[7:4] : r_a[3:0];
    assign w_nib_b   = w_in_high ? r_b[7:4] : r_b[3:0];
    assign w_cin_low = (w_use_cf & r_cf) ^ w_is_sub;
    assign w_nib_cin = w_in_high ? r_c_mid : w_cin_low;
    assign w_sum     = {1'b0, w_nib_a} + {1'b0, w_nib_b ^ {4{w_is_sub}}}
                     + {4'b0000, w_nib_cin};

    always_comb begin
        case (r_op)
            OP_AND:  w_nib_res = w_nib_a & w_nib_b;
            OP_XOR:  w_nib_res = w_nib_a ^ w_nib_b;
            OP_OR:   w_nib_res = w_nib_a | w_nib_b;
            default: w_nib_res = w_sum[3:0];
        endcase
    end

    // Full-width result and flags, meaningful during HIGH only
    logic [7:0] w_r, w_flags, w_xy_src;
    logic       w_zero, w_even, w_ovf, w_h, w_c;

    assign w_r    = {w_nib_res, r_lo_res};
    assign w_zero = r_lo_zero & (w_nib_res == 4'h0);
    // Whole byte is even iff both nibbles share the same parity
    assign w_even = ~(r_lo_even ^ (~^w_nib_res));
    // Operand b as actually seen by the adder decides the overflow sign rule
    assign w_ovf  = (r_a[7] == (r_b[7] ^ w_is_sub)) && (w_r[7] != r_a[7]);
    assign w_h    = (r_op == OP_AND) ? 1'b1 :
                    w_is_logic       ? 1'b0 : (r_c_mid ^ w_is_sub);
    assign w_c    = w_is_logic ? 1'b0 : (w_sum[4] ^ w_is_sub);
    assign w_xy_src = (r_op == OP_CP) ? r_b : w_r;

    always_comb begin
        w_flags    = 8'h00;
        w_flags[7] = w_r[7];
        w_flags[6] = w_zero;
        w_flags[4] = w_h;
        w_flags[2] = w_is_logic ? w_even : w_ovf;
        w_flags[1] = w_is_sub;
        w_flags[0] = w_c;
`ifdef ALU_SEQ_XY_EN
        w_flags[5] = w_xy_src[5];
        w_flags[3] = w_xy_src[3];
`else
        // Undocumented bits read as 0; keep the source net referenced
        w_flags[5] = 1'b0 & w_xy_src[5];
        w_flags[3] = 1'b0 & w_xy_src[3];
`endif
    end

    // Next state and decoded outputs
    // NOTE: every output of this block gets a default first so no path
    // leaves a value unassigned, which would otherwise infer a latch.
    always_comb begin
        w_next_state = r_state;
        busy         = 1'b0;
        done         = 1'b0;
        alu_op_low   = 1'b0;
        case (r_state)
            S_IDLE: if (start) w_next_state = S_LOW;
            S_LOW: begin
                busy         = 1'b1;
                alu_op_low   = 1'b1;
                w_next_state = S_HIGH;
            end
            S_HIGH: begin
                busy         = 1'b1;
                w_next_state = S_DONE;
            end
            S_DONE: begin
                done         = 1'b1;
                w_next_state = start ? S_LOW : S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_state   <= S_IDLE;
            r_op      <= OP_ADD;
            r_a       <= 8'h00;
            r_b       <= 8'h00;
            r_cf      <= 1'b0;
            r_lo_res  <= 4'h0;
            r_c_mid   <= 1'b0;
            r_lo_zero <= 1'b0;
            r_lo_even <= 1'b0;
            r_result  <= 8'h00;
            r_flags   <= 8'h00;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                S_IDLE, S_DONE: if (start) begin
                    r_op <= op_t'(op);
                    r_a  <= op1;
                    r_b  <= op2;
                    r_cf <= cf_in;
                end
                S_LOW: begin
                    r_lo_res  <= w_nib_res;
                    r_c_mid   <= w_sum[4];
                    r_lo_zero <= (w_nib_res == 4'h0);
                    r_lo_even <= ~^w_nib_res;
                end
                S_HIGH: begin
                    // CP reports flags of op1-op2 but leaves the operand intact
                    r_result <= (r_op == OP_CP) ? r_a : w_r;
                    r_flags  <= w_flags;
                end
                default: ;
            endcase
        end
    end

    assign result = r_result;
    assign flags  = r_flags;

endmodule

// File: tb/tb_alu_seq.sv
// -----------------------------------------------------------------------------
// tb_alu_seq -- directed self-checking bench for alu_seq.
// Expected results and flags are hand-computed constants; the Y/X dependent
// ones follow ALU_SEQ_XY_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_alu_seq;

    logic       clk;
    logic       nreset;
    logic       start;
    logic [2:0] op;
    logic [7:0] op1, op2;
    logic       cf_in;
    logic       busy, done, alu_op_low;
    logic [7:0] result, flags;

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [2:0] ADD = 3'd0, ADC = 3'd1, SUB = 3'd2, SBC = 3'd3,
                           AND = 3'd4, XOR = 3'd5, OR  = 3'd6, CP  = 3'd7;

`ifdef ALU_SEQ_XY_EN
    localparam logic [7:0] SUB_FLAGS = 8'h3E, AND_FLAGS = 8'h34, CP_FLAGS = 8'hBB;
`else
    localparam logic [7:0] SUB_FLAGS = 8'h16, AND_FLAGS = 8'h14, CP_FLAGS = 8'h93;
`endif

    alu_seq dut (
        .clk        (clk),
        .nreset     (nreset),
        .start      (start),
        .op         (op),
        .op1        (op1),
        .op2        (op2),
        .cf_in      (cf_in),
        .busy       (busy),
        .done       (done),
        .result     (result),
        .flags      (flags),
        .alu_op_low (alu_op_low)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to 1 time unit after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] o, input logic [7:0] a,
                         input logic [7:0] b, input logic c);
        start = 1'b1;
        op    = o;
        op1   = a;
        op2   = b;
        cf_in = c;
    endtask

    // Garbage on the operand bus after acceptance must not matter
    task automatic scramble();
        start = 1'b0;
        op    = 3'd6;
        op1   = 8'hA5;
        op2   = 8'h3C;
        cf_in = 1'b1;
    endtask

    task automatic test_reset();
        nreset = 1'b0;
        start  = 1'b0;
        op     = 3'd0;
        op1    = 8'h00;
        op2    = 8'h00;
        cf_in  = 1'b0;
        #12;
        n_checks++;
        if ({busy, done, alu_op_low, result, flags} !== 19'h0) begin
            n_errors++;
            $display("FAIL reset_values: got busy=%b done=%b low=%b result=%h flags=%h, expected all zero",
                     busy, done, alu_op_low, result, flags);
        end
        @(negedge clk);
        nreset = 1'b1;
        tick();
        n_checks++;
        if ({busy, done} !== 2'b00) begin
            n_errors++;
            $display("FAIL idle_after_reset: got busy=%b done=%b, expected 0 0", busy, done);
        end
    endtask

    task automatic test_add();
        issue(ADD, 8'h0F, 8'h01, 1'b1);   // cf_in ignored by ADD
        tick();                            // E0
        scramble();
        n_checks++;
        if ({busy, done, alu_op_low} !== 3'b101) begin
            n_errors++;
            $display("FAIL add_low_phase: got busy/done/low=%b, expected 101", {busy, done, alu_op_low});
        end
        tick();                            // E1
        n_checks++;
        if ({busy, done, alu_op_low} !== 3'b100) begin
            n_errors++;
            $display("FAIL add_high_phase: got busy/done/low=%b, expected 100", {busy, done, alu_op_low});
        end
        tick();                            // E2
        n_checks++;
        if ({busy, done, result, flags} !== {2'b01, 8'h10, 8'h10}) begin
            n_errors++;
            $display("FAIL add_done: got busy=%b done=%b result=%h flags=%h, expected 0 1 10 10",
                     busy, done, result, flags);
        end
        tick();
        n_checks++;
        if ({done, result} !== {1'b0, 8'h10}) begin
            n_errors++;
            $display("FAIL add_hold: got done=%b result=%h, expected 0 10", done, result);
        end
    endtask

    task automatic test_sub();
        issue(SUB, 8'h80, 8'h01, 1'b1);
        tick(); scramble(); tick(); tick();
        n_checks++;
        if ({done, result, flags} !== {1'b1, 8'h7F, SUB_FLAGS}) begin
            n_errors++;
            $display("FAIL sub_80_01: got done=%b result=%h flags=%h, expected 1 7f %h",
                     done, result, flags, SUB_FLAGS);
        end
        tick();
    endtask

    task automatic test_adc();
        issue(ADC, 8'hFF, 8'h00, 1'b1);
        tick(); scramble(); tick(); tick();
        n_checks++;
        if ({done, result, flags} !== {1'b1, 8'h00, 8'h51}) begin
            n_errors++;
            $display("FAIL adc_ff_00_c1: got done=%b result=%h flags=%h, expected 1 00 51",
                     done, result, flags);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        issue(XOR, 8'h5A, 8'h5A, 1'b0);
        tick(); scramble(); tick(); tick();
        n_checks++;
        if ({done, result, flags} !== {1'b1, 8'h00, 8'h44}) begin
            n_errors++;
            $display("FAIL xor_5a_5a: got done=%b result=%h flags=%h, expected 1 00 44",
                     done, result, flags);
        end
        issue(AND, 8'hF0, 8'h3C, 1'b0);   // raised during DONE
        tick();                            // E3 accepts
        scramble();
        n_checks++;
        if ({busy, done, alu_op_low} !== 3'b101) begin
            n_errors++;
            $display("FAIL b2b_accept: got busy/done/low=%b, expected 101", {busy, done, alu_op_low});
        end
        n_checks++;
        if ({result, flags} !== {8'h00, 8'h44}) begin
            n_errors++;
            $display("FAIL b2b_hold_prev: got result=%h flags=%h, expected 00 44", result, flags);
        end
        tick(); tick();
        n_checks++;
        if ({done, result, flags} !== {1'b1, 8'h30, AND_FLAGS}) begin
            n_errors++;
            $display("FAIL and_f0_3c: got done=%b result=%h flags=%h, expected 1 30 %h",
                     done, result, flags, AND_FLAGS);
        end
        tick();
    endtask

    task automatic test_cp();
        issue(CP, 8'h10, 8'h28, 1'b1);
        tick(); scramble(); tick(); tick();
        n_checks++;
        if ({done, result, flags} !== {1'b1, 8'h10, CP_FLAGS}) begin
            n_errors++;
            $display("FAIL cp_10_28: got done=%b result=%h flags=%h, expected 1 10 %h",
                     done, result, flags, CP_FLAGS);
        end
        tick();
    endtask

    task automatic test_sbc();
        // 0x00 - 0x00 - 1 = 0xFF, borrow from both nibbles, no overflow
        issue(SBC, 8'h00, 8'h00, 1'b1);
        tick(); scramble(); tick(); tick();
        n_checks++;
`ifdef ALU_SEQ_XY_EN
        if ({done, result, flags} !== {1'b1, 8'hFF, 8'hBB}) begin
`else
        if ({done, result, flags} !== {1'b1, 8'hFF, 8'h93}) begin
`endif
            n_errors++;
            $display("FAIL sbc_00_00_c1: got done=%b result=%h flags=%h", done, result, flags);
        end
        tick();
    endtask

    task automatic test_ignore_start();
        int dones;
        issue(ADD, 8'h0F, 8'h01, 1'b0);
        tick();                            // E0
        issue(OR, 8'h77, 8'h77, 1'b1);     // held high through LOW and HIGH
        tick();                            // E1
        n_checks++;
        if ({busy, alu_op_low} !== 2'b10) begin
            n_errors++;
            $display("FAIL ignore_high_phase: got busy=%b low=%b, expected 1 0", busy, alu_op_low);
        end
        tick();                            // E2
        start = 1'b0;
        n_checks++;
        if ({done, result, flags} !== {1'b1, 8'h10, 8'h10}) begin
            n_errors++;
            $display("FAIL ignore_result: got done=%b result=%h flags=%h, expected 1 10 10",
                     done, result, flags);
        end
        dones = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (done === 1'b1 || busy === 1'b1) dones++;
        end
        n_checks++;
        if (dones !== 0) begin
            n_errors++;
            $display("FAIL ignore_no_queue: got %0d extra busy/done cycles, expected 0", dones);
        end
    endtask

    task automatic test_reset_mid_op();
        int dones;
        issue(ADD, 8'h22, 8'h33, 1'b0);
        tick();                            // E0
        scramble();
        tick();                            // E1, now in HIGH
        #1 nreset = 1'b0;
        #1;
        n_checks++;
        if ({busy, done, alu_op_low, result, flags} !== 19'h0) begin
            n_errors++;
            $display("FAIL reset_mid_op: got busy=%b done=%b low=%b result=%h flags=%h, expected all zero",
                     busy, done, alu_op_low, result, flags);
        end
        @(negedge clk);
        nreset = 1'b1;
        dones = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (done === 1'b1 || busy === 1'b1) dones++;
        end
        n_checks++;
        if ({dones[7:0], result} !== 16'h0000) begin
            n_errors++;
            $display("FAIL reset_discard: got %0d busy/done cycles result=%h, expected 0 00", dones, result);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_adc();
        test_back_to_back();
        test_cp();
        test_sbc();
        test_ignore_start();
        test_reset_mid_op();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
